// File: rtl/rx_block_assembler.sv
// rx_block_assembler
//
// Assembles 128b/130b receive blocks (BLOCK_BYTES payload bytes plus a 2-bit sync
// header) from PIPE receive-data beats of 8, 16 or 32 bits. A finished block is
// presented as one wide word with a single-cycle valid. Framing errors are flagged,
// and saturating counters track completed blocks and framing errors.
//
// Ports:
//   clk             block clock, same domain as the PIPE receive-data stage
//   reset           asynchronous, active-low reset
//   pipe_width      current PIPE width in bits (8, 16 or 32 are legal)
//   data_valid      beat qualifier
//   sync_header     sync header, nonzero only on the first beat of a block
//   electrical_idle receiver electrical idle; aborts any partial block
//   data            beat data, byte 0 = data[7:0] is first on the wire
//   block_valid     one-cycle pulse: block_data/block_type hold a new block
//   block_data      assembled payload, wire byte n at [8n+7:8n]
//   block_type      sync header of the block (2'b10 data, 2'b01 ordered set)
//   block_error     one-cycle framing-error pulse
//   blk_count       completed blocks, saturating
//   err_count       framing errors, saturating
module rx_block_assembler #(
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               pipe_width,
  input  logic                     data_valid,
  input  logic [1:0]               sync_header,
  input  logic                     electrical_idle,
  input  logic [31:0]              data,
  output logic                     block_valid,
  output logic [8*BLOCK_BYTES-1:0] block_data,
  output logic [1:0]               block_type,
  output logic                     block_error,
  output logic [CNT_W-1:0]         blk_count,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned BlkW = 8 * BLOCK_BYTES;
  // Byte counter must be able to hold BLOCK_BYTES itself.
  localparam int unsigned OffW = $clog2(BLOCK_BYTES + 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e            state_q, state_d;
  logic [OffW-1:0]   count_q, count_d;
  logic [5:0]        width_q, width_d;
  logic [1:0]        asm_type_q, asm_type_d;
  logic [BlkW-1:0]   asm_q, asm_d;
  logic              block_valid_q, block_valid_d;
  logic              block_error_q, block_error_d;
  logic [BlkW-1:0]   block_data_q, block_data_d;
  logic [1:0]        block_type_q, block_type_d;
  logic [CNT_W-1:0]  blk_count_q, blk_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic              width_legal;
  logic [2:0]        bpb;
  logic              is_start;
  logic              start;
  logic              wr_en;
  logic [31:0]       wr_base;
  logic [31:0]       new_count;

  // Bytes per beat; zero for an illegal width.
  always_comb begin
    bpb         = 3'd0;
    width_legal = 1'b0;
    case (pipe_width)
      6'd8:  begin bpb = 3'd1; width_legal = 1'b1; end
      6'd16: begin bpb = 3'd2; width_legal = 1'b1; end
      6'd32: begin bpb = 3'd4; width_legal = 1'b1; end
      default: begin bpb = 3'd0; width_legal = 1'b0; end
    endcase
  end

  assign is_start = (sync_header == 2'b01) || (sync_header == 2'b10);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    width_d       = width_q;
    asm_type_d    = asm_type_q;
    asm_d         = asm_q;
    block_valid_d = 1'b0;
    block_error_d = 1'b0;
    block_data_d  = block_data_q;
    block_type_d  = block_type_q;
    start         = 1'b0;
    wr_en         = 1'b0;
    wr_base       = '0;

    // Electrical idle wins over everything, including gap cycles.
    if (electrical_idle) begin
      state_d = StIdle;
      count_d = '0;
    end else if (data_valid) begin
      unique case (state_q)
        StIdle: begin
          // 2'b00 in IDLE is pre-lock filler and is dropped silently.
          if ((sync_header == 2'b11) || (is_start && !width_legal)) begin
            block_error_d = 1'b1;
          end else if (is_start) begin
            start = 1'b1;
          end
        end
        StCollect: begin
          // An illegal width never equals the latched (legal) width, so it
          // lands in the width-change branch.
          if ((sync_header == 2'b11) || (pipe_width != width_q)) begin
            block_error_d = 1'b1;
            state_d       = StIdle;
            count_d       = '0;
          end else if (is_start) begin
            // Premature start: drop the partial block, restart on this beat.
            block_error_d = 1'b1;
            start         = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_base = 32'(count_q);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      if (start) begin
        wr_en      = 1'b1;
        wr_base    = '0;
        asm_type_d = sync_header;
        width_d    = pipe_width;
        state_d    = StCollect;
      end
    end

    new_count = wr_base + 32'(bpb);

    // Scatter the low bpb beat bytes into the assembly register at wr_base.
    for (int unsigned j = 0; j < BLOCK_BYTES; j++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_en && (i < 32'(bpb)) && (32'(j) == wr_base + 32'(i))) begin
          asm_d[8*j +: 8] = data[8*i +: 8];
        end
      end
    end

    // BLOCK_BYTES is a multiple of every legal bpb, so equality is enough.
    if (wr_en) begin
      if (new_count == BLOCK_BYTES) begin
        block_valid_d = 1'b1;
        block_data_d  = asm_d;
        block_type_d  = asm_type_d;
        state_d       = StIdle;
        count_d       = '0;
      end else begin
        count_d = OffW'(new_count);
      end
    end
  end

  // Saturating counters, at most one increment per cycle.
  always_comb begin
    blk_count_d = blk_count_q;
    err_count_d = err_count_q;
    if (block_valid_d && (blk_count_q != '1)) begin
      blk_count_d = blk_count_q + CNT_W'(1);
    end
    if (block_error_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      width_q       <= '0;
      asm_type_q    <= '0;
      asm_q         <= '0;
      block_valid_q <= 1'b0;
      block_error_q <= 1'b0;
      block_data_q  <= '0;
      block_type_q  <= '0;
      blk_count_q   <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      width_q       <= width_d;
      asm_type_q    <= asm_type_d;
      asm_q         <= asm_d;
      block_valid_q <= block_valid_d;
      block_error_q <= block_error_d;
      block_data_q  <= block_data_d;
      block_type_q  <= block_type_d;
      blk_count_q   <= blk_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign block_valid = block_valid_q;
  assign block_error = block_error_q;
  assign block_data  = block_data_q;
  assign block_type  = block_type_q;
  assign blk_count   = blk_count_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/rx_block_assembler.md
Name: rx_block_assembler

Overview:
- Sits directly downstream of the PIPE receive-data stage.
- Consumes its per-clock PIPE data beats (8/16/32-bit), data-valid, sync header and electrical-idle.
- Assembles Gen3+ 128b/130b blocks: 16 payload bytes plus the 2-bit sync header.
- Presents complete blocks to the descrambler/ordered-set decoder as one 128-bit word with a single-cycle valid, flags framing errors, and keeps saturating block/error counters.

Parameters:
- BLOCK_BYTES, 16, payload bytes per block. Must be a multiple of 4.
- CNT_W, 16, width of blk_count.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  block clock, same domain as the PIPE receive-data stage
- reset  input  1  asynchronous, active-low
- pipe_width  input  6  current PIPE width in bits; legal values 8, 16, 32
- data_valid  input  1  beat qualifier
- sync_header  input  2  nonzero only on the first beat of a block
- electrical_idle  input  1  receiver electrical idle
- data  input  32  beat data; byte 0 = data[7:0], the first byte on the wire
- block_valid  output  1  one-cycle pulse, block_data/block_type valid
- block_data  output  8*BLOCK_BYTES  assembled payload; wire byte n at [8n+7:8n]
- block_type  output  2  sync header of the block: 2'b10 data, 2'b01 ordered set
- block_error  output  1  one-cycle framing-error pulse
- blk_count  output  CNT_W  completed blocks, saturating
- err_count  output  ERR_W  framing errors, saturating

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, byte counter 0, captured width 0.
- Bytes per beat bpb = pipe_width/8, valid only for widths 8, 16, 32.
- A beat is a cycle with data_valid=1 and electrical_idle=0.
- Cycles with data_valid=0 are gaps: no state change.
- State IDLE:
  - Beat with sync_header 2'b01 or 2'b10 and legal width:
    - write bpb bytes at offset 0;
    - latch block_type and pipe_width;
    - count=bpb; go to COLLECT.
  - Beat with sync_header 2'b00: discarded silently (pre-lock filler).
  - Beat with sync_header 2'b11, or any start beat with illegal width: block_error, stay IDLE.
- State COLLECT:
  - Beat with sync_header 2'b00 and pipe_width equal to the latched width: write bpb bytes at offset count; count += bpb.
  - When the new count equals BLOCK_BYTES: block_valid=1 on the next cycle, blk_count increments, go to IDLE, count=0.
  - Beat with sync_header 2'b01/2'b10 (premature start): block_error; partial block discarded; the same beat starts a new block (offset 0, new block_type, count=bpb). Stay in COLLECT.
  - Beat with sync_header 2'b11: block_error, go to IDLE.
  - Beat with a changed pipe_width: block_error, go to IDLE.
- electrical_idle=1 in any state: abort to IDLE, count=0, no error, data ignored. Takes priority over all other conditions.
- Latency: block_valid and block_error are registered, asserted 1 cycle after the causing beat. The 16th byte to block_valid is 1 clk.
- block_data/block_type:
  - updated only when a block completes;
  - hold their value after the block_valid pulse until the next completion;
  - partial fills use a separate assembly register, so block_data never shows partial blocks.
- Simultaneous error and restart (premature start): block_error and the new block's start happen in the same beat; no block_valid.
- Counters:
  - blk_count and err_count saturate at all-ones, no wrap;
  - each increments at most once per cycle;
  - both are cleared only by reset.
- Count arithmetic:
  - the counter is wide enough for BLOCK_BYTES;
  - BLOCK_BYTES is a multiple of every legal bpb, so overshoot is impossible.
- Illegal pipe_width (0, 24, ...) while in COLLECT counts as a width change.

Test Plan:
- Width 32:
  - stimulus: beats {hdr=10, data=32'h03020100}, then 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C with hdr=00;
  - response: one cycle after the 4th beat, block_valid=1, block_data=128'h0F0E...0100, block_type=10, blk_count=1.
- Width 8:
  - stimulus: 16 beats 8'h00..8'h0F, hdr=01 on the first beat, data_valid=0 gaps inserted after beats 3 and 9;
  - response: block_valid only after beat 16, block_type=01, same block_data.
- Width 16, premature start:
  - stimulus: 3 beats, then a beat with hdr=10, then 7 more beats;
  - response: block_error pulse after the 4th beat, err_count=1, later block_valid with the bytes of the restarted block only.
- Abort paths:
  - electrical_idle=1 mid-block: response is IDLE, no error, no block_valid; the next fresh block completes normally.
  - pipe_width 32→16 mid-block: response is block_error, err_count increments.
- Saturation and reset:
  - with CNT_W=2, six complete blocks: response is blk_count=3.
  - reset asserted mid-block: all outputs 0 immediately; after release, a full block completes correctly.
  - hdr=11 in IDLE: block_error.
